// File: rtl/id_ex_if.sv
// id_ex_if: decode-to-execute bundle carrying the ID/EX pipeline register's capture inputs and registered outputs.
`default_nettype none

interface id_ex_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
);
  logic               enable;
  logic               flush;
  logic               valid_in;
  logic               dWEN_in;
  logic               dREN_in;
  logic               WEN_in;
  logic               extend_in;
  logic               halt_in;
  logic               reg_dest_in;
  logic [ALUOP_W-1:0] alu_op_in;
  logic [DATA_W-1:0]  rdat1_in;
  logic [DATA_W-1:0]  rdat2_in;
  logic [15:0]        imm16_in;
  logic [REG_W-1:0]   rs_in;
  logic [REG_W-1:0]   rt_in;
  logic [REG_W-1:0]   rd_in;
  logic [DATA_W-1:0]  npc_in;

  logic               valid_out;
  logic               dWEN_out;
  logic               dREN_out;
  logic               WEN_out;
  logic               extend_out;
  logic               halt_out;
  logic               reg_dest_out;
  logic [ALUOP_W-1:0] alu_op_out;
  logic [DATA_W-1:0]  rdat1_out;
  logic [DATA_W-1:0]  rdat2_out;
  logic [15:0]        imm16_out;
  logic [REG_W-1:0]   rs_out;
  logic [REG_W-1:0]   rt_out;
  logic [REG_W-1:0]   rd_out;
  logic [DATA_W-1:0]  npc_out;
  logic [DATA_W-1:0]  imm_ext_out;
  logic [REG_W-1:0]   wsel_out;
  logic               halted;
  logic [CNT_W-1:0]   instr_count;

  modport master (
    output enable, flush, valid_in, dWEN_in, dREN_in, WEN_in, extend_in, halt_in,
           reg_dest_in, alu_op_in, rdat1_in, rdat2_in, imm16_in, rs_in, rt_in,
           rd_in, npc_in,
    input  valid_out, dWEN_out, dREN_out, WEN_out, extend_out, halt_out,
           reg_dest_out, alu_op_out, rdat1_out, rdat2_out, imm16_out, rs_out,
           rt_out, rd_out, npc_out, imm_ext_out, wsel_out, halted, instr_count
  );

  modport slave (
    input  enable, flush, valid_in, dWEN_in, dREN_in, WEN_in, extend_in, halt_in,
           reg_dest_in, alu_op_in, rdat1_in, rdat2_in, imm16_in, rs_in, rt_in,
           rd_in, npc_in,
    output valid_out, dWEN_out, dREN_out, WEN_out, extend_out, halt_out,
           reg_dest_out, alu_op_out, rdat1_out, rdat2_out, imm16_out, rs_out,
           rt_out, rd_out, npc_out, imm_ext_out, wsel_out, halted, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register with flush bubbles, stall hold, sticky halt and instruction counter.
`default_nettype none

module id_ex_latch #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  wire logic CLK,
  input  wire logic nRST,
  id_ex_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic               valid;
    logic               dwen;
    logic               dren;
    logic               wen;
    logic               extend;
    logic               halt;
    logic               reg_dest;
    logic [ALUOP_W-1:0] alu_op;
    logic [DATA_W-1:0]  rdat1;
    logic [DATA_W-1:0]  rdat2;
    logic [15:0]        imm16;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [DATA_W-1:0]  npc;
    logic [DATA_W-1:0]  imm_ext;
    logic [REG_W-1:0]   wsel;
  } stage_t;

  state_t           state, state_nxt;
  stage_t           stage, stage_nxt;
  stage_t           captured;
  logic [CNT_W-1:0] count, count_nxt;

  // Side-effecting control only survives capture when the slot holds a real instruction.
  always_comb begin
    captured          = '0;
    captured.valid    = bus.valid_in;
    captured.dwen     = bus.valid_in & bus.dWEN_in;
    captured.dren     = bus.valid_in & bus.dREN_in;
    captured.wen      = bus.valid_in & bus.WEN_in;
    captured.halt     = bus.valid_in & bus.halt_in;
    captured.extend   = bus.extend_in;
    captured.reg_dest = bus.reg_dest_in;
    captured.alu_op   = bus.alu_op_in;
    captured.rdat1    = bus.rdat1_in;
    captured.rdat2    = bus.rdat2_in;
    captured.imm16    = bus.imm16_in;
    captured.rs       = bus.rs_in;
    captured.rt       = bus.rt_in;
    captured.rd       = bus.rd_in;
    captured.npc      = bus.npc_in;
    captured.imm_ext  = bus.extend_in ? {{(DATA_W-16){bus.imm16_in[15]}}, bus.imm16_in}
                                      : {{(DATA_W-16){1'b0}}, bus.imm16_in};
    captured.wsel     = bus.reg_dest_in ? bus.rt_in : bus.rd_in;
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    count_nxt = count;
    case (state)
      RUN: begin
        if (bus.flush) begin
          stage_nxt = '0;
        end else if (bus.enable) begin
          stage_nxt = captured;
          if (bus.valid_in) begin
            count_nxt = count + CNT_ONE;
          end
          if (bus.valid_in && bus.halt_in) begin
            state_nxt = HALTED;
          end
        end
      end
      HALTED: begin
        // The halt instruction shows for one cycle, then only inert bubbles follow.
        stage_nxt.valid = 1'b0;
        stage_nxt.dwen  = 1'b0;
        stage_nxt.dren  = 1'b0;
        stage_nxt.wen   = 1'b0;
        stage_nxt.halt  = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      stage <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      stage <= stage_nxt;
      count <= count_nxt;
    end
  end

  assign bus.valid_out    = stage.valid;
  assign bus.dWEN_out     = stage.dwen;
  assign bus.dREN_out     = stage.dren;
  assign bus.WEN_out      = stage.wen;
  assign bus.extend_out   = stage.extend;
  assign bus.halt_out     = stage.halt;
  assign bus.reg_dest_out = stage.reg_dest;
  assign bus.alu_op_out   = stage.alu_op;
  assign bus.rdat1_out    = stage.rdat1;
  assign bus.rdat2_out    = stage.rdat2;
  assign bus.imm16_out    = stage.imm16;
  assign bus.rs_out       = stage.rs;
  assign bus.rt_out       = stage.rt;
  assign bus.rd_out       = stage.rd;
  assign bus.npc_out      = stage.npc;
  assign bus.imm_ext_out  = stage.imm_ext;
  assign bus.wsel_out     = stage.wsel;
  assign bus.halted       = (state == HALTED);
  assign bus.instr_count  = count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: directed stimulus with a behavioural reference model checked every cycle, plus literal expectations.
`default_nettype none

module tb_id_ex_latch;

  logic clk;
  logic nrst;
  int   n_pass;
  int   n_total;

  id_ex_if #(.DATA_W(32), .REG_W(5), .ALUOP_W(4), .CNT_W(4)) bus ();

  id_ex_latch #(.DATA_W(32), .REG_W(5), .ALUOP_W(4), .CNT_W(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid, dwen, dren, wen, extend, halt, reg_dest;
    logic [3:0]  alu_op;
    logic [31:0] rdat1, rdat2;
    logic [15:0] imm16;
    logic [4:0]  rs, rt, rd;
    logic [31:0] npc, imm_ext;
    logic [4:0]  wsel;
  } rec_t;

  rec_t m;
  bit   m_halted;
  int   m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // What the EX stage should see if the decode slot were captured right now.
  function automatic rec_t decoded();
    rec_t r;
    r.valid    = bus.valid_in;
    r.dwen     = bus.valid_in && bus.dWEN_in;
    r.dren     = bus.valid_in && bus.dREN_in;
    r.wen      = bus.valid_in && bus.WEN_in;
    r.halt     = bus.valid_in && bus.halt_in;
    r.extend   = bus.extend_in;
    r.reg_dest = bus.reg_dest_in;
    r.alu_op   = bus.alu_op_in;
    r.rdat1    = bus.rdat1_in;
    r.rdat2    = bus.rdat2_in;
    r.imm16    = bus.imm16_in;
    r.rs       = bus.rs_in;
    r.rt       = bus.rt_in;
    r.rd       = bus.rd_in;
    r.npc      = bus.npc_in;
    r.imm_ext  = bus.extend_in ? 32'($signed(bus.imm16_in)) : 32'(bus.imm16_in);
    r.wsel     = bus.reg_dest_in ? bus.rt_in : bus.rd_in;
    return r;
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m        <= '0;
      m_halted <= 1'b0;
      m_cnt    <= 0;
    end else if (m_halted) begin
      m.valid <= 1'b0;
      m.dwen  <= 1'b0;
      m.dren  <= 1'b0;
      m.wen   <= 1'b0;
      m.halt  <= 1'b1;
    end else if (bus.flush) begin
      m <= '0;
    end else if (bus.enable) begin
      m <= decoded();
      if (bus.valid_in) m_cnt <= (m_cnt + 1) % 16;
      if (bus.valid_in && bus.halt_in) m_halted <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("valid_out",    bus.valid_out,    m.valid);
    check("dWEN_out",     bus.dWEN_out,     m.dwen);
    check("dREN_out",     bus.dREN_out,     m.dren);
    check("WEN_out",      bus.WEN_out,      m.wen);
    check("extend_out",   bus.extend_out,   m.extend);
    check("halt_out",     bus.halt_out,     m.halt);
    check("reg_dest_out", bus.reg_dest_out, m.reg_dest);
    check("alu_op_out",   bus.alu_op_out,   m.alu_op);
    check("rdat1_out",    bus.rdat1_out,    m.rdat1);
    check("rdat2_out",    bus.rdat2_out,    m.rdat2);
    check("imm16_out",    bus.imm16_out,    m.imm16);
    check("rs_out",       bus.rs_out,       m.rs);
    check("rt_out",       bus.rt_out,       m.rt);
    check("rd_out",       bus.rd_out,       m.rd);
    check("npc_out",      bus.npc_out,      m.npc);
    check("imm_ext_out",  bus.imm_ext_out,  m.imm_ext);
    check("wsel_out",     bus.wsel_out,     m.wsel);
    check("halted",       bus.halted,       m_halted);
    check("instr_count",  bus.instr_count,  m_cnt[3:0]);
  end

  task automatic idle_inputs();
    bus.enable = 0; bus.flush = 0; bus.valid_in = 0; bus.dWEN_in = 0; bus.dREN_in = 0;
    bus.WEN_in = 0; bus.extend_in = 0; bus.halt_in = 0; bus.reg_dest_in = 0;
    bus.alu_op_in = 0; bus.rdat1_in = 0; bus.rdat2_in = 0; bus.imm16_in = 0;
    bus.rs_in = 0; bus.rt_in = 0; bus.rd_in = 0; bus.npc_in = 0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    nrst    = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check("rst valid_out", bus.valid_out, 0);
    check("rst instr_count", bus.instr_count, 0);
    check("rst halted", bus.halted, 0);
    nrst = 1'b1;

    // ADD with sign-extended immediate, rt destination
    bus.enable = 1; bus.valid_in = 1; bus.alu_op_in = 4'h2; bus.rdat1_in = 32'h5;
    bus.imm16_in = 16'hFFFC; bus.extend_in = 1; bus.reg_dest_in = 1; bus.rt_in = 9;
    bus.rd_in = 3; bus.npc_in = 32'h104;
    @(negedge clk);
    check("t1 imm_ext", bus.imm_ext_out, 32'hFFFF_FFFC);
    check("t1 wsel", bus.wsel_out, 9);
    check("t1 valid", bus.valid_out, 1);
    check("t1 count", bus.instr_count, 1);
    bus.extend_in = 0; bus.reg_dest_in = 0;
    @(negedge clk);
    check("t1 zext imm_ext", bus.imm_ext_out, 32'h0000_FFFC);
    check("t1 rd wsel", bus.wsel_out, 3);
    check("t1 count2", bus.instr_count, 2);

    // SW-like capture then three stalled cycles with changing inputs
    bus.dWEN_in = 1; bus.rdat2_in = 32'h1234_5678; bus.rt_in = 4; bus.imm16_in = 16'h0010;
    @(negedge clk);
    check("t2 dWEN", bus.dWEN_out, 1);
    check("t2 count", bus.instr_count, 3);
    bus.enable = 0;
    for (int i = 0; i < 3; i++) begin
      bus.rdat2_in = 32'hA000_0000 + i; bus.dWEN_in = i[0]; bus.valid_in = 1;
      @(negedge clk);
      check("t2 hold rdat2", bus.rdat2_out, 32'h1234_5678);
      check("t2 hold count", bus.instr_count, 3);
    end

    // flush beats enable
    bus.enable = 1; bus.flush = 1; bus.valid_in = 1; bus.WEN_in = 1; bus.dWEN_in = 1;
    @(negedge clk);
    check("t3 valid", bus.valid_out, 0);
    check("t3 WEN", bus.WEN_out, 0);
    check("t3 rdat1", bus.rdat1_out, 0);
    check("t3 count", bus.instr_count, 3);

    // invalid slot: controls squashed, data still loads
    bus.flush = 0; bus.valid_in = 0; bus.WEN_in = 1; bus.dWEN_in = 0;
    bus.rdat2_in = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t4 WEN", bus.WEN_out, 0);
    check("t4 rdat2", bus.rdat2_out, 32'hDEAD_BEEF);
    check("t4 count", bus.instr_count, 3);

    // both memory strobes pass through
    bus.valid_in = 1; bus.dWEN_in = 1; bus.dREN_in = 1; bus.WEN_in = 0;
    @(negedge clk);
    check("both dWEN", bus.dWEN_out, 1);
    check("both dREN", bus.dREN_out, 1);
    check("both count", bus.instr_count, 4);

    // halt, then further enabled valid traffic is ignored
    bus.dWEN_in = 0; bus.dREN_in = 0; bus.WEN_in = 1; bus.halt_in = 1;
    @(negedge clk);
    check("t5 halt valid", bus.valid_out, 1);
    check("t5 halt_out", bus.halt_out, 1);
    check("t5 halt WEN", bus.WEN_out, 1);
    check("t5 halt count", bus.instr_count, 5);
    bus.halt_in = 0; bus.dWEN_in = 1;
    for (int i = 0; i < 5; i++) begin
      bus.flush = (i == 2); bus.rdat1_in = 32'h77 + i;
      @(negedge clk);
      check("t5 halted", bus.halted, 1);
      check("t5 valid", bus.valid_out, 0);
      check("t5 WEN", bus.WEN_out, 0);
      check("t5 count", bus.instr_count, 5);
    end
    bus.flush = 0;
    nrst = 1'b0;
    #1;
    check("t5 rst halted", bus.halted, 0);
    check("t5 rst halt_out", bus.halt_out, 0);
    check("t5 rst count", bus.instr_count, 0);
    @(negedge clk);
    nrst = 1'b1;

    // counter wrap over 17 valid captures
    bus.dWEN_in = 0; bus.WEN_in = 1; bus.enable = 1; bus.valid_in = 1;
    for (int i = 0; i < 17; i++) begin
      bus.npc_in = 32'h400 + 4 * i;
      @(negedge clk);
    end
    check("t6 wrap count", bus.instr_count, 1);
    check("t6 npc", bus.npc_out, 32'h440);

    // asynchronous reset between edges
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("t6 async valid", bus.valid_out, 0);
    check("t6 async npc", bus.npc_out, 0);
    check("t6 async count", bus.instr_count, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("t6 post count", bus.instr_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
